// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer slice.
//   ACC_BYTE / ACC_HALF / ACC_WORD : one-hot access size encodings
//   sb_entry_t                     : one buffered store {word adr, lane data, byte enables}
package store_buffer_pkg;

  localparam logic [2:0] ACC_BYTE = 3'b001;
  localparam logic [2:0] ACC_HALF = 3'b010;
  localparam logic [2:0] ACC_WORD = 3'b100;

  typedef struct packed {
    logic [29:0] adr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of the core-side access port and the memory-side read/write ports
// of the store buffer.
//   slave  : the store buffer itself
//   master : the environment (core + memory)
// Write port handshake: mem_wr_v_o is held high with stable adr/data/be
// until a cycle in which mem_wr_gnt_i is also high; that cycle transfers one
// entry and the next entry (if any) is presented on the following cycle.
// mem_wr_gnt_i is only meaningful while mem_wr_v_o is high.
interface store_buffer_if #(parameter int XLEN = 32);
  logic            adr_v_i;
  logic [XLEN-1:0] adr_i;
  logic            is_store_i;
  logic [XLEN-1:0] store_data_i;
  logic [2:0]      access_size_i;
  logic [XLEN-1:0] load_data_o;
  logic            misalign_o;
  logic [XLEN-3:0] mem_rd_adr_o;
  logic [XLEN-1:0] mem_rd_data_i;
  logic            mem_wr_v_o;
  logic [XLEN-3:0] mem_wr_adr_o;
  logic [XLEN-1:0] mem_wr_data_o;
  logic [3:0]      mem_wr_be_o;
  logic            mem_wr_gnt_i;
  logic            empty_o;
  logic            full_o;
  logic            overflow_o;

  modport slave (
    input  adr_v_i, adr_i, is_store_i, store_data_i, access_size_i,
    input  mem_rd_data_i, mem_wr_gnt_i,
    output load_data_o, misalign_o, mem_rd_adr_o,
    output mem_wr_v_o, mem_wr_adr_o, mem_wr_data_o, mem_wr_be_o,
    output empty_o, full_o, overflow_o
  );

  modport master (
    output adr_v_i, adr_i, is_store_i, store_data_i, access_size_i,
    output mem_rd_data_i, mem_wr_gnt_i,
    input  load_data_o, misalign_o, mem_rd_adr_o,
    input  mem_wr_v_o, mem_wr_adr_o, mem_wr_data_o, mem_wr_be_o,
    input  empty_o, full_o, overflow_o
  );
endinterface

// File: rtl/store_lane_align.sv
// Combinational store lane alignment, also usable by the load path.
//   adr_lo       in  2   byte offset within the word
//   size         in  3   one-hot access size
//   data         in  32  right-justified store data
//   data_aligned out 32  data moved to its byte lanes
//   be           out 4   byte enables for the access
//   misalign     out 1   half at odd offset or word at non-zero offset
module store_lane_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]  adr_lo,
  input  logic [2:0]  size,
  input  logic [31:0] data,
  output logic [31:0] data_aligned,
  output logic [3:0]  be,
  output logic        misalign
);
  logic [31:0] masked;

  always_comb begin
    masked   = '0;
    be       = '0;
    misalign = 1'b0;
    case (size)
      ACC_BYTE: begin
        masked = {24'b0, data[7:0]};
        be     = 4'b0001 << adr_lo;
      end
      ACC_HALF: begin
        masked   = {16'b0, data[15:0]};
        be       = 4'b0011 << adr_lo;
        misalign = adr_lo[0];
      end
      ACC_WORD: begin
        masked   = data;
        be       = 4'b1111;
        misalign = (adr_lo != 2'b00);
      end
      default: ;
    endcase
    data_aligned = masked << {adr_lo, 3'b000};
  end
endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core data port and data memory.
// Stores are queued in program order and drained through a byte-enabled
// write port with grant back-pressure; loads read memory combinationally
// with pending buffered bytes forwarded on top.
//   clk, reset : clock, synchronous active-high reset
//   bus        : store_buffer_if.slave (core access, memory read, memory write,
//                empty/full/overflow status)
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  sb_entry_t       entries [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     count;
  logic            overflow;

  logic [31:0]     al_data;
  logic [3:0]      al_be;
  logic            al_misalign;
  logic            push;
  logic            pop;
  logic            push_ok;
  logic            full;
  logic [31:0]     fwd;
  logic [PW-1:0]   idx;

  store_lane_align u_align (
    .adr_lo       (bus.adr_i[1:0]),
    .size         (bus.access_size_i),
    .data         (bus.store_data_i),
    .data_aligned (al_data),
    .be           (al_be),
    .misalign     (al_misalign)
  );

  assign full    = (count == (PW+1)'(DEPTH));
  assign pop     = (count != '0) && bus.mem_wr_gnt_i;
  assign push    = bus.adr_v_i && bus.is_store_i && !al_misalign;
  // At full a push is only accepted when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  // Entry storage needs no reset: validity is implied by rd_ptr/count.
  // When full with a simultaneous pop, wr_ptr == rd_ptr and the popped head
  // slot is reused; the head was already consumed combinationally.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      entries[wr_ptr] <= '{adr: bus.adr_i[XLEN-1:2], data: al_data, be: al_be};
    end
  end

  // Forwarding: walk oldest to youngest so a younger matching byte overwrites
  // an older one, which gives the same result as a youngest-first priority
  // scan. The head still forwards while being popped, because memory only
  // reflects the write from the next cycle on.
  always_comb begin
    fwd = bus.mem_rd_data_i;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (((PW+1)'(k) < count) && (entries[idx].adr == bus.adr_i[XLEN-1:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (entries[idx].be[b]) fwd[8*b +: 8] = entries[idx].data[8*b +: 8];
        end
      end
    end
  end

  assign bus.load_data_o   = fwd;
  assign bus.misalign_o    = al_misalign;
  assign bus.mem_rd_adr_o  = bus.adr_i[XLEN-1:2];
  assign bus.mem_wr_v_o    = (count != '0);
  assign bus.mem_wr_adr_o  = entries[rd_ptr].adr;
  assign bus.mem_wr_data_o = entries[rd_ptr].data;
  assign bus.mem_wr_be_o   = entries[rd_ptr].be;
  assign bus.empty_o       = (count == '0);
  assign bus.full_o        = full;
  assign bus.overflow_o    = overflow;
endmodule
